reg_page_file: RTL and testbench

- Small multi-ported general-purpose register page for the distributed processor core: 16 × 32-bit registers.
- Two independent read ports and one write port.
- Feeds the ALU/operand path, which reads two source operands per cycle and writes back one result.
- Purely storage plus read muxing; no arithmetic.

---
 rtl/reg_page_pkg.sv | 23 ++
 rtl/reg_page_read_port.sv | 61 ++++++
 rtl/reg_page_file.sv | 102 ++++++++++
 tb/tb_reg_page_file.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/reg_page_pkg.sv
// Shared definitions for the general-purpose register page.
//
// Contents:
//   DATA_WIDTH_DEFAULT  default register / data-port width (32)
//   NUM_REGS_DEFAULT    default register count (16)
//   reg_data_t          one register word at default width
//   reg_addr_t          register index at default count
//   REG_RESET_VAL       value every register takes on reset
//
// Optional build macro used by the page: REG_PAGE_WRITE_BYPASS_EN
// (see reg_page_file / reg_page_read_port).

package reg_page_pkg;

  localparam int unsigned DATA_WIDTH_DEFAULT = 32;
  localparam int unsigned NUM_REGS_DEFAULT   = 16;

  typedef logic [31:0] reg_data_t;
  typedef logic [3:0]  reg_addr_t;

  localparam reg_data_t REG_RESET_VAL = 32'h0;

endpackage : reg_page_pkg

// File: rtl/reg_page_read_port.sv
// One combinational read port of the register page.
//
// Selects one register word out of the flattened register array. When built
// with REG_PAGE_WRITE_BYPASS_EN, a pending write to the same index is
// forwarded so the new value is visible before the clock edge; otherwise the
// stored (old) value is returned during a colliding write.
//
// Parameters:
//   DATA_WIDTH    width of each register
//   NUM_REGS      number of registers (power of two >= 2)
// Ports:
//   read_addr     register index to read
//   regs_flat     all registers, register i at [i*DATA_WIDTH +: DATA_WIDTH]
//   bypass_valid  a write is being accepted this cycle (already gated by reset)
//   bypass_addr   index of that write
//   bypass_data   data of that write
//   read_data     selected register contents

module reg_page_read_port #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16,
  localparam int unsigned ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic [ADDR_WIDTH-1:0]          read_addr,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat,
  input  logic                           bypass_valid,
  input  logic [ADDR_WIDTH-1:0]          bypass_addr,
  input  logic [DATA_WIDTH-1:0]          bypass_data,
  output logic [DATA_WIDTH-1:0]          read_data
);

  logic [DATA_WIDTH-1:0] array_data;

  // Decoded mux over the array; every index is legal since NUM_REGS is 2^ADDR_WIDTH.
  always_comb begin
    array_data = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (read_addr == ADDR_WIDTH'(i)) begin
        array_data = regs_flat[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef REG_PAGE_WRITE_BYPASS_EN
  always_comb begin
    read_data = array_data;
    if (bypass_valid && (bypass_addr == read_addr)) begin
      read_data = bypass_data;
    end
  end
`else
  // Forwarding inputs are kept on the port so both builds share one interface.
  logic unused_bypass;
  assign unused_bypass = ^{bypass_valid, bypass_addr, bypass_data};

  always_comb begin
    read_data = array_data;
  end
`endif

endmodule : reg_page_read_port

// File: rtl/reg_page_file.sv
// General-purpose register page: NUM_REGS x DATA_WIDTH storage with two
// combinational read ports and one synchronous write port.
//
// Register 0 is an ordinary writable register. Reset is synchronous and
// active-low and clears every register; it takes priority over a write in the
// same cycle.
//
// Build option: REG_PAGE_WRITE_BYPASS_EN
//   undefined: a read colliding with a write returns the old value until the
//              edge, the new value afterwards.
//   defined:   a colliding read forwards write_data in the write cycle
//              (suppressed while rst_n is low). Stored state is identical.
//
// Parameters:
//   DATA_WIDTH    register / data-port width
//   NUM_REGS      register count, power of two >= 2
// Ports:
//   clk           clock, state changes on rising edge
//   rst_n         synchronous active-low reset
//   read_addr_0   index for read port 0
//   read_addr_1   index for read port 1
//   write_addr    index for the write port
//   write_data    data to write
//   write_enable  active-high write strobe
//   reg_0_out     contents of register read_addr_0
//   reg_1_out     contents of register read_addr_1

module reg_page_file
  import reg_page_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int unsigned NUM_REGS   = NUM_REGS_DEFAULT,
  localparam int unsigned ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] read_addr_0,
  input  logic [ADDR_WIDTH-1:0] read_addr_1,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write_enable,
  output logic [DATA_WIDTH-1:0] reg_0_out,
  output logic [DATA_WIDTH-1:0] reg_1_out
);

  logic [DATA_WIDTH-1:0]          regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]          regs_d [NUM_REGS];
  logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat;
  logic                           bypass_valid;

  // Next state: only the addressed register takes write_data.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (write_enable && (write_addr == ADDR_WIDTH'(i))) begin
        regs_d[i] = write_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (!rst_n) begin
        regs_q[i] <= DATA_WIDTH'(REG_RESET_VAL);
      end else begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flatten
    assign regs_flat[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

  // A write during reset is discarded, so it must not be forwarded either.
  assign bypass_valid = write_enable & rst_n;

  reg_page_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_read_port_0 (
    .read_addr    (read_addr_0),
    .regs_flat    (regs_flat),
    .bypass_valid (bypass_valid),
    .bypass_addr  (write_addr),
    .bypass_data  (write_data),
    .read_data    (reg_0_out)
  );

  reg_page_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_read_port_1 (
    .read_addr    (read_addr_1),
    .regs_flat    (regs_flat),
    .bypass_valid (bypass_valid),
    .bypass_addr  (write_addr),
    .bypass_data  (write_data),
    .read_data    (reg_1_out)
  );

endmodule : reg_page_file

// File: tb/tb_reg_page_file.sv
// Directed self-checking bench for reg_page_file (default parameters).

module tb_reg_page_file;
  import reg_page_pkg::*;

  logic      clk;
  logic      rst_n;
  reg_addr_t read_addr_0;
  reg_addr_t read_addr_1;
  reg_addr_t write_addr;
  reg_data_t write_data;
  logic      write_enable;
  reg_data_t reg_0_out;
  reg_data_t reg_1_out;

  int unsigned n_checks;
  int unsigned n_errors;

`ifdef REG_PAGE_WRITE_BYPASS_EN
  localparam reg_data_t CollisionExp = 32'h2;
`else
  localparam reg_data_t CollisionExp = 32'h1;
`endif

  reg_page_file u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .read_addr_0  (read_addr_0),
    .read_addr_1  (read_addr_1),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .write_enable (write_enable),
    .reg_0_out    (reg_0_out),
    .reg_1_out    (reg_1_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input reg_data_t obs, input reg_data_t exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled
  // 1ns after it, well away from the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input reg_addr_t addr, input reg_data_t data);
    write_enable = 1'b1;
    write_addr   = addr;
    write_data   = data;
    tick();
    write_enable = 1'b0;
  endtask

  task automatic read_both(input string tag, input reg_addr_t a0, input reg_addr_t a1,
                           input reg_data_t e0, input reg_data_t e1);
    read_addr_0 = a0;
    read_addr_1 = a1;
    #1;
    check({tag, "_p0"}, reg_0_out, e0);
    check({tag, "_p1"}, reg_1_out, e1);
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    rst_n        = 1'b0;
    read_addr_0  = '0;
    read_addr_1  = '0;
    // Write held active through reset must be discarded.
    write_enable = 1'b1;
    write_addr   = 4'd3;
    write_data   = 32'hFFFF_FFFF;
    tick();
    tick();
    rst_n        = 1'b1;
    write_enable = 1'b0;

    for (int i = 0; i < 16; i++) begin
      read_both($sformatf("reset_a%0d", i), reg_addr_t'(i), reg_addr_t'(15 - i), 32'h0, 32'h0);
    end

    // Write/read all registers, sweep without clocking.
    for (int i = 0; i < 16; i++) begin
      write_reg(reg_addr_t'(i), 32'hA5A5_0000 + reg_data_t'(i));
    end
    for (int i = 0; i < 16; i++) begin
      read_both($sformatf("sweep_a%0d", i), reg_addr_t'(i), reg_addr_t'(15 - i),
                32'hA5A5_0000 + reg_data_t'(i), 32'hA5A5_0000 + reg_data_t'(15 - i));
    end

    // Write-enable gating.
    write_reg(4'd5, 32'h1234_5678);
    write_enable = 1'b0;
    write_addr   = 4'd5;
    write_data   = 32'hDEAD_BEEF;
    tick();
    read_both("gate", 4'd5, 4'd4, 32'h1234_5678, 32'hA5A5_0004);

    // Read/write collision on both ports.
    write_reg(4'd7, 32'h1);
    read_addr_0  = 4'd7;
    read_addr_1  = 4'd7;
    write_enable = 1'b1;
    write_addr   = 4'd7;
    write_data   = 32'h2;
    #1;
    check("coll_during_p0", reg_0_out, CollisionExp);
    check("coll_during_p1", reg_1_out, CollisionExp);
    tick();
    write_enable = 1'b0;
    #1;
    check("coll_after_p0", reg_0_out, 32'h2);
    check("coll_after_p1", reg_1_out, 32'h2);

    // Back-to-back writes.
    write_reg(4'd9, 32'h10);
    read_both("b2b_first", 4'd9, 4'd9, 32'h10, 32'h10);
    write_reg(4'd9, 32'h20);
    write_reg(4'd4, 32'h30);
    read_both("b2b_final", 4'd9, 4'd4, 32'h20, 32'h30);
    read_both("b2b_neighbour", 4'd8, 4'd10, 32'hA5A5_0008, 32'hA5A5_000A);

    // Reset mid-operation.
    for (int i = 0; i < 16; i++) begin
      write_reg(reg_addr_t'(i), 32'hC000_0100 + reg_data_t'(i));
    end
    read_both("prereset", 4'd0, 4'd15, 32'hC000_0100, 32'hC000_010F);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      read_both($sformatf("midreset_a%0d", i), reg_addr_t'(i), reg_addr_t'(15 - i),
                32'h0, 32'h0);
    end
    write_reg(4'd2, 32'h55);
    read_both("post_reset_wr", 4'd2, 4'd3, 32'h55, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_reg_page_file
